swim_cmd_ctrl: RTL and testbench
================================

Name: swim_cmd_ctrl

Overview:
Byte-command sequencer between the USB UART byte streams and the SWIM line hardware. It accepts one command byte at a time from the UART out-stream and sequences one of three operations:
- the SWIM entry pulse generator;
- a line reset, driving the pin low;
- a target sync-pulse capture.

It then returns status bytes on the UART in-stream. It is the only driver of the SWIM entry enable and the line drive-low request.

Parameters:
LRST_CYCLES, 6144, clk cycles the line is held low for LINE_RESET (128 us at 48 MHz)
SYNC_MIN_CYCLES, 640, minimum low width accepted as a target sync pulse
TIMEOUT_CYCLES, 48000, sync-wait timeout, measured from command acceptance
ENTRY_TIMEOUT, 1048576, maximum wait for entry_rdy after entry_en
CNT_W, 21, width of internal counters; must hold the largest parameter

Ports:
clk  in  1  system clock (48 MHz)
rst  in  1  synchronous reset, active-low
uart_out_data  in  8  command byte from host
uart_out_valid  in  1  command byte valid
uart_out_ready  out  1  controller can accept a command
uart_in_data  out  8  status byte to host
uart_in_valid  out  1  status byte valid
uart_in_ready  in  1  host stream accepts status byte
entry_en  out  1  one-cycle start pulse to the entry pulse generator
entry_rdy  in  1  one-cycle done pulse from the entry pulse generator
swim_drive_low  out  1  request the pad to drive SWIM low (open-drain enable)
swim_in  in  1  asynchronous SWIM pad input
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst==0 at a clk edge) values:
  - state=IDLE; all counters 0.
  - Outputs: uart_in_valid=0, uart_in_data=0x00, entry_en=0, swim_drive_low=0, busy=0.
  - Reset mid-operation aborts the operation immediately and sends no status byte.
- swim_in passes through a 2-flop synchronizer (swim_s), giving 2 cycles of latency.
- uart_out_ready = (state==IDLE). A byte is accepted on a cycle with uart_out_valid && uart_out_ready.
- Command codes:
  - 0x01 ENTRY
  - 0x02 LINE_RESET
  - 0x03 SYNC_WAIT
  - any other value: no line activity; status 0xEE.
- Status bytes:
  - success: 0x80|cmd
  - timeout/failure: 0xC0|cmd
  - unknown command: 0xEE
- States:
  - IDLE: on an accepted byte, decode and transition on the next edge.
  - ENTRY_WAIT:
    - entry_en=1 for exactly the first cycle in this state; counter counts cycles.
    - entry_rdy -> RESP0 with 0x81.
    - counter reaches ENTRY_TIMEOUT -> RESP0 with 0xC1.
    - entry_rdy in the same cycle as the timeout: success wins.
  - LRST:
    - swim_drive_low=1 for exactly LRST_CYCLES cycles, then deasserts.
    - Next state RESP0 with 0x82.
  - SYNC_HIGH: swim_drive_low=0; waits for swim_s==0, then -> SYNC_LOW with the width counter cleared.
  - SYNC_LOW:
    - Width counter increments each cycle, saturating at all-ones.
    - On swim_s==1: if width >= SYNC_MIN_CYCLES -> RESP0 with 0x83, and RESP1 carries min(width>>4, 0xFF). Otherwise the pulse is a glitch; return to SYNC_HIGH.
  - Timeout counter for SYNC_HIGH/SYNC_LOW:
    - Runs continuously from command acceptance and is not reset by glitches.
    - Reaching TIMEOUT_CYCLES in either state -> RESP0 with 0xC3; no RESP1.
    - A valid pulse end in the same cycle as the timeout: success wins.
  - RESP0 / RESP1:
    - uart_in_valid=1 with uart_in_data held stable until a cycle with uart_in_ready=1.
    - That handshake cycle completes the byte. Next state is RESP1 if a second byte is pending, else IDLE.
    - uart_in_valid drops to 0 in the cycle after the last handshake unless a new byte is presented.
- entry_rdy outside ENTRY_WAIT is ignored.
- swim_in activity outside SYNC states is ignored.
- uart_out_valid is ignored while busy; the byte stays upstream (no drop, no duplication).
- Latency:
  - accepted byte -> entry_en or swim_drive_low: 1 cycle.
  - unknown command -> uart_in_valid: 1 cycle.

Decomposition:
- Package swim_pkg holds:
  - command codes CMD_ENTRY/CMD_LRST/CMD_SYNC;
  - status constants ST_OK_BIT (0x80), ST_FAIL_BIT (0xC0), ST_UNKNOWN (0xEE);
  - state enum {IDLE, ENTRY_WAIT, LRST, SYNC_HIGH, SYNC_LOW, RESP0, RESP1}.
- One natural sub-module, swim_pulse_meter:
  - function: 2-flop synchronizer, low-width saturating counter, pulse_done/width outputs;
  - instantiated once, with a clear input driven from the FSM.

Test Plan:
- Bench parameters for all scenarios: LRST_CYCLES=8, SYNC_MIN_CYCLES=4, TIMEOUT_CYCLES=100, ENTRY_TIMEOUT=50.
- Send 0x01; return entry_rdy 20 cycles after entry_en -> entry_en is exactly one pulse, status 0x81, uart_out_ready low until the handshake completes.
- Send 0x01; never assert entry_rdy -> status 0xC1 after 50 cycles. A repeat where entry_rdy lands on the timeout cycle -> 0x81.
- Send 0x02 -> swim_drive_low high for exactly 8 cycles, starting 1 cycle after acceptance; then status 0x82.
- Send 0x03; drive swim_in low 2 cycles (glitch), then low 80 cycles -> status 0x83 followed by 0x05. Hold uart_in_ready low 10 cycles -> data stays stable, no loss.
- Send 0x03 with swim_in held high -> 0xC3 after 100 cycles, no second byte. Send 0x7F -> 0xEE, no line activity.
- Drop rst to 0 mid-LRST -> swim_drive_low=0, busy=0, no status emitted. The next 0x02 behaves normally.

Source files
------------

// File: rtl/swim_pkg.sv
// swim_pkg: command codes, status bytes, FSM states and a byte-saturation helper
// shared by the SWIM command sequencer.
package swim_pkg;
  localparam logic [7:0] CMD_ENTRY   = 8'h01;
  localparam logic [7:0] CMD_LRST    = 8'h02;
  localparam logic [7:0] CMD_SYNC    = 8'h03;
  localparam logic [7:0] ST_OK_BIT   = 8'h80;
  localparam logic [7:0] ST_FAIL_BIT = 8'hC0;
  localparam logic [7:0] ST_UNKNOWN  = 8'hEE;

  typedef enum logic [2:0] {IDLE, ENTRY_WAIT, LRST, SYNC_HIGH, SYNC_LOW, RESP0, RESP1} state_t;

  function automatic logic [7:0] sat_byte(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction
endpackage

// File: rtl/swim_pulse_meter.sv
// swim_pulse_meter: 2-flop synchronizer for the SWIM pad plus a saturating
// low-width counter; width counts every uncleared cycle, pulse_done marks the rising edge.
module swim_pulse_meter #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swim_i,
  input  logic             clear_i,
  output logic             swim_s_o,
  output logic             pulse_done_o,
  output logic [CNT_W-1:0] width_o
);
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] width_q, width_d;

  assign width_d = clear_i ? '0 : width_q + CNT_W'(~&width_q);

  always_ff @(posedge clk)
    if (!rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      width_q <= '0;
    end else begin
      s1_q    <= swim_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      width_q <= width_d;
    end

  assign swim_s_o     = s2_q;
  assign pulse_done_o = s2_q & ~s3_q;
  assign width_o      = width_q;
endmodule

// File: rtl/swim_cmd_ctrl.sv
// swim_cmd_ctrl: byte-command sequencer between the UART streams and the SWIM line
// (entry pulse, line reset, sync-pulse capture) returning status bytes to the host.
module swim_cmd_ctrl
  import swim_pkg::*;
#(
  parameter int LRST_CYCLES     = 6144,
  parameter int SYNC_MIN_CYCLES = 640,
  parameter int TIMEOUT_CYCLES  = 48000,
  parameter int ENTRY_TIMEOUT   = 1048576,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_out_data,
  input  logic       uart_out_valid,
  output logic       uart_out_ready,
  output logic [7:0] uart_in_data,
  output logic       uart_in_valid,
  input  logic       uart_in_ready,
  output logic       entry_en,
  input  logic       entry_rdy,
  output logic       swim_drive_low,
  input  logic       swim_in,
  output logic       busy
);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, width;
  logic [7:0]       data_q, resp1_q;
  logic             valid_q, has2_q, entry_en_q, drive_q;
  logic             swim_s, pulse_done, meter_clear, hs, sync_ok, sync_to;

  swim_pulse_meter #(.CNT_W(CNT_W)) u_meter (
    .clk          (clk),
    .rst          (rst),
    .swim_i       (swim_in),
    .clear_i      (meter_clear),
    .swim_s_o     (swim_s),
    .pulse_done_o (pulse_done),
    .width_o      (width)
  );

  // The low-detect cycle in SYNC_HIGH is already counted, so width equals the full low time.
  assign meter_clear = !(state_q == SYNC_LOW || (state_q == SYNC_HIGH && !swim_s));
  assign hs          = valid_q && uart_in_ready;
  assign sync_ok     = state_q == SYNC_LOW && pulse_done && width >= CNT_W'(SYNC_MIN_CYCLES);
  assign sync_to     = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk)
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      resp1_q    <= '0;
      valid_q    <= 1'b0;
      has2_q     <= 1'b0;
      entry_en_q <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      entry_en_q <= 1'b0;
      case (state_q)
        IDLE: if (uart_out_valid) begin
          cnt_q  <= '0;
          has2_q <= 1'b0;
          if (uart_out_data == CMD_ENTRY) begin
            state_q    <= ENTRY_WAIT;
            entry_en_q <= 1'b1;
          end else if (uart_out_data == CMD_LRST) begin
            state_q <= LRST;
            drive_q <= 1'b1;
          end else if (uart_out_data == CMD_SYNC) begin
            state_q <= SYNC_HIGH;
          end else begin
            state_q <= RESP0;
            data_q  <= ST_UNKNOWN;
            valid_q <= 1'b1;
          end
        end
        ENTRY_WAIT: if (entry_rdy || cnt_q == CNT_W'(ENTRY_TIMEOUT - 1)) begin
          state_q <= RESP0;
          valid_q <= 1'b1;
          data_q  <= (entry_rdy ? ST_OK_BIT : ST_FAIL_BIT) | CMD_ENTRY;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        LRST: if (cnt_q == CNT_W'(LRST_CYCLES - 1)) begin
          drive_q <= 1'b0;
          state_q <= RESP0;
          valid_q <= 1'b1;
          data_q  <= ST_OK_BIT | CMD_LRST;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        SYNC_HIGH, SYNC_LOW: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (sync_ok || sync_to) begin
            state_q <= RESP0;
            valid_q <= 1'b1;
            has2_q  <= sync_ok;
            data_q  <= (sync_ok ? ST_OK_BIT : ST_FAIL_BIT) | CMD_SYNC;
            resp1_q <= sat_byte(32'(width >> 4));
          end else if (state_q == SYNC_HIGH && !swim_s) begin
            state_q <= SYNC_LOW;
          end else if (state_q == SYNC_LOW && pulse_done) begin
            state_q <= SYNC_HIGH;
          end
        end
        RESP0: if (hs) begin
          state_q <= has2_q ? RESP1 : IDLE;
          valid_q <= has2_q;
          data_q  <= has2_q ? resp1_q : data_q;
        end
        RESP1: if (hs) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign uart_out_ready = state_q == IDLE;
  assign busy           = state_q != IDLE;
  assign uart_in_valid  = valid_q;
  assign uart_in_data   = data_q;
  assign entry_en       = entry_en_q;
  assign swim_drive_low = drive_q;
endmodule

// File: tb/tb_swim_cmd_ctrl.sv
// tb_swim_cmd_ctrl: directed and randomized command sequences checked against a
// cycle-count model of the command rules.
`timescale 1ns/1ps
module tb_swim_cmd_ctrl;
  import swim_pkg::*;

  localparam int LRST_N = 8;
  localparam int MIN_N  = 4;
  localparam int TO_N   = 100;
  localparam int ET_N   = 50;

  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] uart_out_data = 8'h00, uart_in_data;
  logic       uart_out_valid = 1'b0, uart_out_ready, uart_in_valid, uart_in_ready = 1'b0;
  logic       entry_en, entry_rdy = 1'b0, swim_drive_low, swim_in = 1'b1, busy;

  int n_chk = 0, n_fail = 0;
  int gaps[$], lens[$];
  bit line[$];

  swim_cmd_ctrl #(
    .LRST_CYCLES     (LRST_N),
    .SYNC_MIN_CYCLES (MIN_N),
    .TIMEOUT_CYCLES  (TO_N),
    .ENTRY_TIMEOUT   (ET_N),
    .CNT_W           (21)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_out_data  (uart_out_data),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .entry_en       (entry_en),
    .entry_rdy      (entry_rdy),
    .swim_drive_low (swim_drive_low),
    .swim_in        (swim_in),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(uart_in_valid), 0);
    check({tag, "_drive"}, 32'(swim_drive_low), 0);
    check({tag, "_entry_en"}, 32'(entry_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'(uart_out_ready), 1);
  endtask

  task automatic build_line();
    line.delete();
    foreach (gaps[i]) begin
      repeat (gaps[i]) line.push_back(1'b1);
      repeat (lens[i]) line.push_back(1'b0);
    end
  endtask

  // Expected outcome straight from the command rules, counted in clock edges after acceptance.
  task automatic predict(input logic [7:0] cmd, input int rdy_at, output int lat,
                         output logic [7:0] b0, output logic two, output logic [7:0] b1,
                         output int drv);
    int k0;
    two = 1'b0;
    b1  = 8'h00;
    drv = 0;
    if (cmd == CMD_ENTRY) begin
      lat = (rdy_at >= 0 && rdy_at < ET_N) ? rdy_at + 1 : ET_N;
      b0  = (rdy_at >= 0 && rdy_at < ET_N) ? 8'h81 : 8'hC1;
    end else if (cmd == CMD_LRST) begin
      lat = LRST_N;
      b0  = 8'h82;
      drv = LRST_N;
    end else if (cmd == CMD_SYNC) begin
      lat = TO_N;
      b0  = 8'hC3;
      k0  = 0;
      foreach (gaps[i]) begin
        k0 += gaps[i];
        if (!two && lens[i] >= MIN_N && k0 + lens[i] + 2 <= TO_N - 1) begin
          two = 1'b1;
          lat = k0 + lens[i] + 3;
          b0  = 8'h83;
          b1  = 8'((lens[i] / 16 > 255) ? 255 : lens[i] / 16);
        end
        k0 += lens[i];
      end
    end else begin
      lat = 0;
      b0  = 8'hEE;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!uart_out_ready && n < 300) begin
      tick();
      n++;
    end
    check("ready_before_send", 32'(uart_out_ready), 1);
    uart_out_valid = 1'b1;
    uart_out_data  = b;
    tick();
    uart_out_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic recv(input logic [7:0] b0, input logic two, input logic [7:0] b1, input int stall0);
    logic [7:0] exp;
    logic       stable;
    int         ns;
    for (int i = 0; i < (two ? 2 : 1); i++) begin
      exp    = (i == 0) ? b0 : b1;
      stable = 1'b1;
      ns     = (i == 0) ? stall0 : int'($urandom_range(0, 2));
      for (int s = 0; s < ns; s++) begin
        if (uart_in_valid !== 1'b1 || uart_in_data !== exp) stable = 1'b0;
        tick();
      end
      check("resp_stable", 32'(stable), 1);
      check("resp_valid", 32'(uart_in_valid), 1);
      check("resp_data", 32'(uart_in_data), 32'(exp));
      uart_in_ready = 1'b1;
      tick();
      uart_in_ready = 1'b0;
    end
    check_idle("after_resp");
  endtask

  task automatic run(input logic [7:0] cmd, input int rdy_at, input int exp_lat,
                     input logic [7:0] b0, input logic two, input logic [7:0] b1,
                     input int exp_drv, input int stall0);
    int lat = -1, en_cnt = 0, drv_cnt = 0, drv_first = -1, rdy_hi = 0;
    if (cmd != CMD_SYNC) begin
      line.delete();
      repeat (64) line.push_back(1'($urandom_range(0, 1)));
    end
    send(cmd);
    for (int k = 0; k < 200; k++) begin
      if (uart_in_valid) begin
        lat = k;
        break;
      end
      en_cnt += int'(entry_en);
      if (swim_drive_low) begin
        drv_cnt++;
        if (drv_first < 0) drv_first = k;
      end
      if (uart_out_ready) rdy_hi++;
      swim_in        = (k < line.size()) ? line[k] : 1'b1;
      entry_rdy      = (cmd == CMD_ENTRY) ? (k == rdy_at) : ($urandom_range(0, 3) == 0);
      uart_out_valid = 1'($urandom_range(0, 1));
      uart_out_data  = 8'($urandom);
      tick();
    end
    swim_in        = 1'b1;
    entry_rdy      = 1'b0;
    uart_out_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("entry_en_pulses", en_cnt, 32'(cmd == CMD_ENTRY));
    check("drive_low_cycles", drv_cnt, exp_drv);
    check("drive_low_start", drv_first, (exp_drv > 0) ? 0 : -1);
    check("ready_while_busy", rdy_hi, 0);
    if (lat >= 0) recv(b0, two, b1, stall0);
  endtask

  initial begin
    int         lat, drv, vis, rdy;
    logic [7:0] cmd, b0, b1;
    logic       two;

    repeat (3) tick();
    check_idle("reset");
    check("reset_data", 32'(uart_in_data), 0);
    rst = 1'b1;
    tick();

    run(CMD_ENTRY, 20, 21, 8'h81, 1'b0, 8'h00, 0, 0);
    run(CMD_ENTRY, -1, 50, 8'hC1, 1'b0, 8'h00, 0, 2);
    run(CMD_ENTRY, 49, 50, 8'h81, 1'b0, 8'h00, 0, 1);
    run(CMD_ENTRY, 48, 49, 8'h81, 1'b0, 8'h00, 0, 0);
    run(CMD_LRST, -1, 8, 8'h82, 1'b0, 8'h00, 8, 3);

    gaps = '{3, 5};
    lens = '{2, 80};
    build_line();
    run(CMD_SYNC, -1, 93, 8'h83, 1'b1, 8'h05, 0, 10);

    gaps.delete();
    lens.delete();
    build_line();
    run(CMD_SYNC, -1, 100, 8'hC3, 1'b0, 8'h00, 0, 1);

    gaps = '{20};
    lens = '{77};
    build_line();
    run(CMD_SYNC, -1, 100, 8'h83, 1'b1, 8'h04, 0, 0);

    gaps = '{21};
    lens = '{77};
    build_line();
    run(CMD_SYNC, -1, 100, 8'hC3, 1'b0, 8'h00, 0, 0);

    gaps = '{2, 2};
    lens = '{3, 4};
    build_line();
    run(CMD_SYNC, -1, 14, 8'h83, 1'b1, 8'h00, 0, 2);

    run(8'h7F, -1, 0, 8'hEE, 1'b0, 8'h00, 0, 4);

    send(CMD_LRST);
    repeat (3) tick();
    check("lrst_mid_drive", 32'(swim_drive_low), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_idle("mid_reset");
    vis = 0;
    repeat (10) begin
      vis += int'(uart_in_valid);
      tick();
    end
    check("mid_reset_no_status", vis, 0);
    run(CMD_LRST, -1, 8, 8'h82, 1'b0, 8'h00, 8, 0);

    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: cmd = CMD_ENTRY;
        1: cmd = CMD_LRST;
        2: cmd = CMD_SYNC;
        default: begin
          cmd = 8'($urandom);
          while (cmd >= 8'h01 && cmd <= 8'h03) cmd = 8'($urandom);
        end
      endcase
      rdy = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, ET_N + 10));
      gaps.delete();
      lens.delete();
      repeat ($urandom_range(0, 4)) begin
        gaps.push_back(int'($urandom_range(1, 6)));
        lens.push_back(int'($urandom_range(1, 30)));
      end
      build_line();
      predict(cmd, rdy, lat, b0, two, b1, drv);
      run(cmd, rdy, lat, b0, two, b1, drv, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
